// File: rtl/gate_sweep_sequencer.sv
// Self-test sequencer for a 2-input gate datapath (OR(a,~b), XOR, XNOR, AND).
// A start edge sweeps all four (a,b) vectors through the gate unit and compares
// each registered result against a fixed truth table, reporting on the user I/O.
module gate_sweep_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StApply, StCheck, StDone} state_e;

    logic       clk;
    logic       rst;
    logic       start;
    logic       step_mode;
    logic       step;
    logic       fault_inj;
    logic [1:0] op;

    assign clk       = io_in[0];
    assign rst       = io_in[1];
    assign start     = io_in[2];
    assign step_mode = io_in[3];
    assign step      = io_in[4];
    assign fault_inj = io_in[5];
    assign op        = io_in[7:6];

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] start_sync_q, step_sync_q;
    logic                   start_edge_q, step_edge_q;
    logic                   start_rise_q, step_rise_q;
    logic [1:0]             vec_q, vec_d;
    logic [1:0]             op_q, op_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   y_q, y_d;
    logic                   fail_q, fail_d;
    logic                   mismatch;
    logic                   gate_out;
    logic [3:0]             exp_row;
    logic                   advance;

    // Synchronize start/step and register a one-cycle rising-edge pulse for each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync_q <= '0;
            step_sync_q  <= '0;
            start_edge_q <= 1'b0;
            step_edge_q  <= 1'b0;
            start_rise_q <= 1'b0;
            step_rise_q  <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start};
            step_sync_q  <= {step_sync_q[SYNC_STAGES-2:0], step};
            start_edge_q <= start_sync_q[SYNC_STAGES-1];
            step_edge_q  <= step_sync_q[SYNC_STAGES-1];
            start_rise_q <= start_sync_q[SYNC_STAGES-1] & ~start_edge_q;
            step_rise_q  <= step_sync_q[SYNC_STAGES-1] & ~step_edge_q;
        end
    end

    // Gate unit and the reference truth table (bit i = vector i).
    always_comb begin
        gate_out = 1'b0;
        exp_row  = 4'b0000;
        unique case (op_q)
            2'b00: begin gate_out = vec_q[0] | ~vec_q[1];   exp_row = 4'b1011; end
            2'b01: begin gate_out = vec_q[0] ^ vec_q[1];    exp_row = 4'b0110; end
            2'b10: begin gate_out = ~(vec_q[0] ^ vec_q[1]); exp_row = 4'b1001; end
            2'b11: begin gate_out = vec_q[0] & vec_q[1];    exp_row = 4'b1000; end
            default: ;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic: start accepted only when idle or done; step_mode is live in APPLY.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        fail_d   = fail_q;
        mismatch = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_rise_q) begin
                    state_d = StApply;
                    op_d    = op;
                    vec_d   = '0;
                    cnt_d   = '0;
                    fail_d  = 1'b0;
                end
            end
            StApply: begin
                advance = step_mode ? step_rise_q : (cnt_q == CntW'(HOLD_CYCLES - 1));
                if (advance) begin
                    state_d = StCheck;
                    y_d     = gate_out ^ fault_inj;
                end else if (!step_mode) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                mismatch = (y_q != exp_row[vec_q]);
                if (mismatch) begin
                    fail_d = 1'b1;
                end
                if (vec_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    state_d = StApply;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status outputs are decoded from registered state so reset clears them at once.
    always_comb begin
        io_out[0] = vec_q[0];
        io_out[1] = vec_q[1];
        io_out[2] = y_q;
        io_out[3] = (state_q == StApply) || (state_q == StCheck);
        io_out[4] = (state_q == StDone);
        io_out[5] = (state_q == StDone) && !fail_q;
        io_out[6] = fail_q;
        io_out[7] = mismatch;
    end

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Directed bench for gate_sweep_sequencer: expected per-vector results are queued
// when a sweep is started and popped as each CHECK cycle is reached.
module tb_gate_sweep_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic       fault_inj = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int errors = 0;
    int checks = 0;

    // Entry layout: {mismatch, y, b, a}
    logic [3:0] sb_q[$];

    assign io_in = {op, fault_inj, step, step_mode, start, rst, clk};

    gate_sweep_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(1)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic model_gate(input logic [1:0] o, input logic a, input logic b);
        case (o)
            2'b00:   return !(!a && b);
            2'b01:   return a != b;
            2'b10:   return a == b;
            default: return a && b;
        endcase
    endfunction

    function automatic logic exp_bit(input logic [1:0] o, input logic [1:0] v);
        logic [3:0] t;
        case (o)
            2'b00:   t = 4'b1011;
            2'b01:   t = 4'b0110;
            2'b10:   t = 4'b1001;
            default: t = 4'b1000;
        endcase
        return t[v];
    endfunction

    task automatic push_sweep(input logic [1:0] o, input logic f);
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            logic       y;
            vv = 2'(v);
            y  = model_gate(o, vv[0], vv[1]) ^ f;
            sb_q.push_back({y != exp_bit(o, vv), y, vv[1], vv[0]});
        end
    endtask

    // Compare {mismatch, y, b, a, busy} against the next queued vector.
    task automatic check_vec(input string tag);
        logic [3:0] e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            e = sb_q.pop_front();
            check(tag, {3'b000, io_out[7], io_out[2], io_out[1], io_out[0], io_out[3]},
                  {3'b000, e, 1'b1});
        end
    endtask

    // Called at a falling edge; returns at the falling edge after edge k+3.
    task automatic start_sweep(input logic [1:0] o, input logic f);
        op        = o;
        fault_inj = f;
        start     = 1'b1;
        push_sweep(o, f);
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        check("busy_k2", {7'b0, io_out[3]}, 8'h00);
        cyc();
        check("busy_k3", {7'b0, io_out[3]}, 8'h01);
        check("fail_clr", {7'b0, io_out[6]}, 8'h00);
    endtask

    task automatic free_run_checks(input string tag);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_vec(tag);
            cyc();
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_out", io_out, 8'h00);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        check("post_reset_idle", io_out, 8'h00);

        // Sweep A: free-run XOR, clean
        start_sweep(2'b01, 1'b0);
        free_run_checks("xor_vec");
        check("xor_done", io_out, 8'b0011_0011);

        // Sweep B: free-run OR(a,~b) with fault injection -> mismatch on every vector
        start_sweep(2'b00, 1'b1);
        free_run_checks("orn_fault_vec");
        check("orn_fault_done", io_out, 8'b0101_0011);

        // Sweep C: restart from DONE with fail set; op change and start re-pulse mid-sweep
        start_sweep(2'b10, 1'b0);
        op = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_vec("xnor_vec");
            if (i == 0) start = 1'b1;
            cyc();
            if (i == 0) start = 1'b0;
        end
        check("xnor_done", io_out, 8'b0011_0111);
        repeat (6) cyc();
        check("xnor_done_hold", io_out, 8'b0011_0111);

        // Sweep D: step mode AND; frozen without steps, one vector per step edge
        step_mode = 1'b1;
        start_sweep(2'b11, 1'b0);
        repeat (8) cyc();
        check("step_frozen", {3'b000, io_out[7], io_out[4], io_out[3], io_out[1], io_out[0]},
              8'b0000_0100);
        for (int i = 0; i < 4; i++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            cyc();
            cyc();
            cyc();
            check_vec("and_step_vec");
            cyc();
        end
        check("and_step_done", io_out, 8'b0011_0111);
        step_mode = 1'b0;

        // Sweep E: reset asserted at vec=2 aborts with no clock edge
        start_sweep(2'b01, 1'b0);
        cyc();
        check_vec("abort_vec");
        cyc();
        cyc();
        check_vec("abort_vec");
        cyc();
        check("abort_at_vec2", {6'b0, io_out[1], io_out[0]}, 8'b0000_0010);
        #2 rst = 1'b1;
        #1 check("async_reset_out", io_out, 8'h00);
        sb_q.delete();
        cyc();
        check("reset_held_out", io_out, 8'h00);
        rst = 1'b0;
        cyc();
        start_sweep(2'b01, 1'b0);
        free_run_checks("post_abort_vec");
        check("post_abort_done", io_out, 8'b0011_0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
